// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit message words into 512-bit blocks, appends
// the 0x80 marker and the 64-bit bit length, and handshakes each block with the core.
module sha256_padder (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         start,
  output logic         last_block,
  output logic [511:0] block,
  input  logic         core_digest_update,
  input  logic         core_done,
  output logic         msg_done
);

  typedef enum logic [1:0] {FILL, ISSUE, WAIT, PAD} state_t;

  state_t            state_q, state_d;
  logic [0:15][31:0] blk_q, blk_d;
  logic [3:0]        widx_q, widx_d;
  logic [63:0]       len_q, len_d;
  logic              last_block_q, last_block_d;
  logic              need_pad_q, need_pad_d;
  logic              marker_placed_q, marker_placed_d;
  logic              msg_done_q, msg_done_d;

  logic [31:0] data_word;
  logic [4:0]  mark_slot;
  logic [6:0]  p_off;
  logic [63:0] len_acc;
  logic        marker_in_data;

  assign in_ready   = (state_q == FILL);
  assign start      = (state_q == ISSUE);
  assign last_block = last_block_q;
  assign block      = blk_q;
  assign msg_done   = msg_done_q;

  // Incoming word with unused bytes cleared; a partial final word carries its own 0x80.
  always_comb begin
    data_word      = '0;
    marker_in_data = in_last && (in_nbytes inside {[3'd1:3'd3]});
    for (int b = 0; b < 4; b++) begin
      if (3'(b) < in_nbytes)
        data_word[31-8*b -: 8] = in_data[31-8*b -: 8];
      else if (marker_in_data && 3'(b) == in_nbytes)
        data_word[31-8*b -: 8] = 8'h80;
    end
    mark_slot = (in_nbytes >= 3'd4) ? ({1'b0, widx_q} + 5'd1) : {1'b0, widx_q};
    p_off     = {mark_slot, 2'b00} + (marker_in_data ? {4'b0, in_nbytes} : 7'd0) + 7'd1;
    len_acc   = len_q + {58'b0, in_nbytes, 3'b000};
  end

  always_comb begin
    state_d         = state_q;
    blk_d           = blk_q;
    widx_d          = widx_q;
    len_d           = len_q;
    last_block_d    = last_block_q;
    need_pad_d      = need_pad_q;
    marker_placed_d = marker_placed_q;
    msg_done_d      = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          len_d         = len_acc;
          blk_d[widx_q] = data_word;
          if (!in_last) begin
            if (widx_q == 4'd15) begin
              state_d      = ISSUE;
              last_block_d = 1'b0;
              need_pad_d   = 1'b0;
            end else begin
              widx_d = widx_q + 4'd1;
            end
          end else begin
            // Full or empty final word: marker goes at byte 0 of the next free slot.
            if (!marker_in_data && mark_slot != 5'd16)
              blk_d[mark_slot[3:0]] = 32'h8000_0000;
            if (p_off <= 7'd56) begin
              blk_d[14]    = len_acc[63:32];
              blk_d[15]    = len_acc[31:0];
              last_block_d = 1'b1;
              need_pad_d   = 1'b0;
            end else begin
              last_block_d    = 1'b0;
              need_pad_d      = 1'b1;
              marker_placed_d = (mark_slot != 5'd16);
            end
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!last_block_q && core_digest_update) begin
          blk_d   = '0;
          widx_d  = 4'd0;
          state_d = need_pad_q ? PAD : FILL;
        end else if (last_block_q && core_done) begin
          blk_d        = '0;
          widx_d       = 4'd0;
          len_d        = '0;
          last_block_d = 1'b0;
          msg_done_d   = 1'b1;
          state_d      = FILL;
        end
      end
      PAD: begin
        blk_d = '0;
        if (!marker_placed_q)
          blk_d[0] = 32'h8000_0000;
        blk_d[14]    = len_q[63:32];
        blk_d[15]    = len_q[31:0];
        last_block_d = 1'b1;
        need_pad_d   = 1'b0;
        state_d      = ISSUE;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= FILL;
      blk_q           <= '0;
      widx_q          <= '0;
      len_q           <= '0;
      last_block_q    <= 1'b0;
      need_pad_q      <= 1'b0;
      marker_placed_q <= 1'b0;
      msg_done_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      blk_q           <= blk_d;
      widx_q          <= widx_d;
      len_q           <= len_d;
      last_block_q    <= last_block_d;
      need_pad_q      <= need_pad_d;
      marker_placed_q <= marker_placed_d;
      msg_done_q      <= msg_done_d;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: table vectors, hand sequences and random messages,
// each checked against a byte-level SHA-256 padding model.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         start;
  logic         last_block;
  logic [511:0] block;
  logic         core_digest_update;
  logic         core_done;
  logic         msg_done;

  sha256_padder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
    .start(start), .last_block(last_block), .block(block),
    .core_digest_update(core_digest_update), .core_done(core_done),
    .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int start_count = 0;

  logic [7:0]   msg[$];
  logic [511:0] exp_q[$];
  logic [511:0] last_seen;

  always @(negedge clk) if (start === 1'b1) start_count++;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Standard padding: message, 0x80, zeros to 56 mod 64, big-endian 64-bit bit length.
  function automatic void build_expected();
    logic [7:0]   q[$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    q = msg;
    bitlen = 64'(msg.size()) * 64'd8;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int i = 7; i >= 0; i--) q.push_back(bitlen[8*i +: 8]);
    exp_q.delete();
    for (int b = 0; b < q.size() / 64; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = q[64*b + j];
      exp_q.push_back(blk);
    end
  endfunction

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int  t;
    logic acc;
    in_valid = 1'b1; in_data = d; in_last = last; in_nbytes = nb;
    t = 0;
    forever begin
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
      t++;
      if (t > 500) begin
        vectors++; miscompares++;
        $display("FAIL accept_timeout in_ready stuck 0 (wanted 1)");
        break;
      end
    end
  endtask

  task automatic drive_msg(input bit empty_last);
    int n, nw, rem;
    logic [31:0] d;
    logic [2:0]  nb;
    n  = msg.size();
    nw = empty_last ? n / 4 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      rem = n - 4*w;
      nb  = (rem >= 4) ? 3'd4 : 3'(rem);
      d   = $urandom;
      for (int b = 0; b < 4; b++) if (b < rem) d[31-8*b -: 8] = msg[4*w + b];
      send_word(d, !empty_last && (w == nw - 1), nb);
    end
    if (empty_last) send_word($urandom, 1'b1, 3'd0);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic core_model(input int nblk);
    int t;
    for (int k = 0; k < nblk; k++) begin
      t = 0;
      while (start !== 1'b1 && t < 500) begin @(negedge clk); t++; end
      if (t >= 500) begin
        vectors++; miscompares++;
        $display("FAIL start_timeout block %0d got no start (wanted one)", k);
        return;
      end
      chk("block", block, exp_q[k]);
      chk("last_block", 512'(last_block), 512'(k == nblk - 1));
      last_seen = block;
      @(negedge clk);
      chk("start_width", 512'(start), 512'(0));
      if ($urandom_range(0, 2) == 0) begin
        if (k == nblk - 1) core_digest_update = 1'b1; else core_done = 1'b1;
        @(negedge clk);
        core_digest_update = 1'b0; core_done = 1'b0;
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      chk("block_hold", block, exp_q[k]);
      if (k == nblk - 1) begin
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("msg_done_pulse", 512'(msg_done), 512'(1));
        @(negedge clk);
        chk("msg_done_clear", 512'(msg_done), 512'(0));
      end else begin
        core_digest_update = 1'b1;
        @(negedge clk);
        core_digest_update = 1'b0;
      end
    end
  endtask

  task automatic make_msg(input int len, input bit rnd);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(rnd ? 8'($urandom) : 8'(8'h61 + i));
  endtask

  task automatic run_msg(input int len, input bit empty_last, input bit rnd);
    int base;
    make_msg(len, rnd);
    build_expected();
    base = start_count;
    fork
      drive_msg(empty_last);
      core_model(exp_q.size());
    join
    chk("start_count", 512'(start_count - base), 512'(exp_q.size()));
  endtask

  typedef struct {
    int          len;
    bit          empty_last;
    logic [31:0] w0;
    logic [31:0] w15;
  } vec_t;

  vec_t vt[11];

  initial begin
    int t;
    vt[0]  = '{0,   1'b1, 32'h8000_0000, 32'h0000_0000};
    vt[1]  = '{3,   1'b0, 32'h6162_6380, 32'h0000_0018};
    vt[2]  = '{55,  1'b0, 32'h6162_6364, 32'h0000_01B8};
    vt[3]  = '{56,  1'b0, 32'h0000_0000, 32'h0000_01C0};
    vt[4]  = '{56,  1'b1, 32'h0000_0000, 32'h0000_01C0};
    vt[5]  = '{64,  1'b0, 32'h8000_0000, 32'h0000_0200};
    vt[6]  = '{64,  1'b1, 32'h8000_0000, 32'h0000_0200};
    vt[7]  = '{128, 1'b0, 32'h8000_0000, 32'h0000_0400};
    vt[8]  = '{60,  1'b0, 32'h0000_0000, 32'h0000_01E0};
    vt[9]  = '{62,  1'b0, 32'h0000_0000, 32'h0000_01F0};
    vt[10] = '{52,  1'b1, 32'h6162_6364, 32'h0000_01A0};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = '0;
    core_digest_update = 1'b0; core_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'(1));
    chk("rst_start", 512'(start), 512'(0));
    chk("rst_last_block", 512'(last_block), 512'(0));
    chk("rst_msg_done", 512'(msg_done), 512'(0));
    chk("rst_block", block, '0);

    foreach (vt[i]) begin
      run_msg(vt[i].len, vt[i].empty_last, 1'b0);
      chk($sformatf("vec%0d_w0", i), 512'(last_seen[511:480]), 512'(vt[i].w0));
      chk($sformatf("vec%0d_w15", i), 512'(last_seen[31:0]), 512'(vt[i].w15));
      $display("vector %0d: len=%0d empty_last=%0d blocks=%0d", i, vt[i].len, vt[i].empty_last, exp_q.size());
    end

    // Reset while the core holds a final block: block is dropped, no further start.
    make_msg(3, 1'b0);
    build_expected();
    drive_msg(1'b0);
    t = 0;
    while (start !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("wait_start_seen", 512'(start), 512'(1));
    @(negedge clk);
    t = start_count;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("wait_rst_in_ready", 512'(in_ready), 512'(1));
    chk("wait_rst_block", block, '0);
    chk("wait_rst_last", 512'(last_block), 512'(0));
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("wait_rst_no_msg_done", 512'(msg_done), 512'(0));
    repeat (10) @(negedge clk);
    chk("wait_rst_no_start", 512'(start_count - t), 512'(0));
    run_msg(3, 1'b0, 1'b0);
    chk("post_rst_w15", 512'(last_seen[31:0]), 512'(32'h0000_0018));
    $display("reset-in-WAIT sequence done");

    for (int r = 0; r < 20; r++) begin
      int len;
      bit el;
      len = $urandom_range(0, 150);
      el  = (len % 4 == 0) ? bit'($urandom_range(0, 1)) : 1'b0;
      if (len == 0) el = 1'b1;
      run_msg(len, el, 1'b1);
      $display("random %0d: len=%0d empty_last=%0d blocks=%0d", r, len, el, exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  message word present.
REQ-004 SHALL have port: in_ready  output  1  padder accepts word this cycle.
REQ-005 SHALL have port: in_data  input  32  message word, big-endian; first byte in [31:24].
REQ-006 SHALL have port: in_last  input  1  word is final word of message.
REQ-007 SHALL have port: in_nbytes  input  3  valid bytes in word, 1..4 (MSB-aligned); 0 legal only with in_last, meaning empty final word.
REQ-008 SHALL have port: start  output  1  one-cycle pulse to sha256_core launching a block.
REQ-009 SHALL have port: last_block  output  1  block is final block of message; held from start until core done.
REQ-010 SHALL have port: block  output  512  block to core; word0 = [511:480].
REQ-011 SHALL have port: core_digest_update  input  1  core finished a non-final block.
REQ-012 SHALL have port: core_done  input  1  core finished the final block.
REQ-013 SHALL have port: msg_done  output  1  one-cycle pulse, message digest valid at core.

Function
REQ-014 SHALL implement states FILL, ISSUE, WAIT, PAD.
REQ-015 SHALL, in FILL, drive in_ready=1 and write each accepted word (in_valid&in_ready) to word index widx (0..15), then increment widx.
REQ-016 SHALL zero unused low bytes of a partial last word and place 0x80 at byte in_nbytes of that word; if in_nbytes==4 or 0, 0x80 goes at byte 0 of the next word slot.
REQ-017 SHALL keep a 64-bit message bit-length counter, adding 8*in_nbytes per accepted word, wrapping modulo 2^64.
REQ-018 SHALL define p = byte offset in block immediately after the 0x80 byte; final block iff p<=56, otherwise a further PAD block is needed.
REQ-019 SHALL, when final block, write the bit length into words 14 (high) and 15 (low), zero words between, set last_block=1.
REQ-020 SHALL, on 16th word accepted without in_last, go to ISSUE with last_block=0.
REQ-021 SHALL, when in_last arrives with p>56, or with 64 data bytes in block (0x80 not placed), issue the block with last_block=0 and enter PAD afterwards.
REQ-022 SHALL, in PAD, build an all-zero block with 0x80000000 in word0 only if 0x80 not yet placed, length in words 14-15, last_block=1, then go to ISSUE.
REQ-023 SHALL, in ISSUE, assert start for exactly one cycle (cycle after the triggering word), then go to WAIT.
REQ-024 SHALL hold block and last_block stable from start until the core response.
REQ-025 SHALL drive in_ready=0 in ISSUE, WAIT, PAD; in_valid then is ignored.
REQ-026 SHALL, in WAIT, on core_digest_update with last_block=0, clear buffer and widx, go to FILL or PAD as recorded.
REQ-027 SHALL, in WAIT, on core_done with last_block=1, pulse msg_done next cycle, clear length counter, go to FILL.
REQ-028 SHALL ignore core_digest_update/core_done outside WAIT and the mismatched one inside WAIT.

Reset
REQ-029 SHALL, with reset high at clk edge: state=FILL, widx=0, length=0, block=0, start=0, last_block=0, msg_done=0; in_ready=1 the cycle after reset deasserts.
REQ-030 SHALL abandon any in-flight block on reset, including during WAIT, without issuing further start.

Verification
REQ-031 SHALL cover: empty message (in_last, nbytes=0) -> one start, block word0=0x80000000, words1..15=0, last_block=1.
REQ-032 SHALL cover: "abc" as 0x61626300, nbytes=3, last -> word0=0x61626380, word15=0x00000018, last_block=1; msg_done one cycle after core_done.
REQ-033 SHALL cover: 56-byte message (14 full words) -> block1 word14=0x80000000, word15=0, last_block=0; after core_digest_update block2 all zero except word15=0x000001C0, last_block=1.
REQ-034 SHALL cover: 64-byte message -> block1 pure data, last_block=0; block2 word0=0x80000000, word15=0x00000200, last_block=1.
REQ-035 SHALL cover: reset asserted in WAIT -> start stays 0, in_ready=1 after release, next "abc" message gives word15=0x00000018.
REQ-036 SHALL cover: in_valid held high through ISSUE/WAIT -> no word accepted until FILL; 128-byte message yields three starts, final word15=0x00000400.
